regfile_sb: RTL and testbench

- Parametrised successor to the 3-port register file: one write port, two combinational read ports, generic WIDTH/DEPTH and an optional hardwired-zero register 0.
- Adds a per-register busy scoreboard for hazard detection by the decode stage.
- Adds a sequential clear-sweep FSM that zeroes the array one entry per cycle after reset or on request. The array itself has no reset.
- Sits between decode (issue/read) and writeback in the single-issue core.

---
 rtl/regfile_sb.sv | 121 ++++++++++++
 tb/tb_regfile_sb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with busy scoreboard and clear-sweep FSM.
// Optional write-through forwarding under REGFILE_SB_BYPASS_EN.
module regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  output logic             ready,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_addr,
  output logic             busy1,
  output logic             busy2
);

  typedef enum logic {SWEEP, IDLE} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic [DEPTH-1:0]   busy_q, busy_d;
  logic [WIDTH-1:0]   rf_q [DEPTH];

  logic               mem_we;
  logic [AW-1:0]      mem_wa;
  logic [WIDTH-1:0]   mem_wd;
  logic               wa_ok, issue_ok;

  assign wa_ok    = !((ZERO_REG != 0) && (wa == '0));
  assign issue_ok = !((ZERO_REG != 0) && (issue_addr == '0));
  assign ready    = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    mem_we  = 1'b0;
    mem_wa  = wa;
    mem_wd  = wd;
    case (state_q)
      SWEEP: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
          busy_d  = '0;
        end else begin
          if (we && wa_ok) begin
            mem_we     = 1'b1;
            busy_d[wa] = 1'b0;
          end
          // Issue is applied after the write so a new producer wins.
          if (issue_en && issue_ok) busy_d[issue_addr] = 1'b1;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Storage carries no reset; the sweep is what makes it valid.
  always_ff @(posedge clk) begin
    if (mem_we) rf_q[mem_wa] <= mem_wd;
  end

  logic [AW-1:0]    ra_a   [2];
  logic [WIDTH-1:0] rd_a   [2];
  logic             busy_a [2];

  assign ra_a[0] = ra1;
  assign ra_a[1] = ra2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_a[p]   = '0;
      busy_a[p] = 1'b0;
      if (ready && !((ZERO_REG != 0) && (ra_a[p] == '0))) begin
        rd_a[p]   = rf_q[ra_a[p]];
        busy_a[p] = busy_q[ra_a[p]];
`ifdef REGFILE_SB_BYPASS_EN
        if (we && wa_ok && (ra_a[p] == wa)) begin
          rd_a[p]   = wd;
          busy_a[p] = 1'b0;
        end
`endif
      end
    end
  end

  assign rd1   = rd_a[0];
  assign rd2   = rd_a[1];
  assign busy1 = busy_a[0];
  assign busy2 = busy_a[1];

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - randomized and directed checks of regfile_sb against a behavioural model.
module tb_regfile_sb;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_req = 1'b0;
  logic             ready;
  logic             we = 1'b0;
  logic [AW-1:0]    wa = '0;
  logic [WIDTH-1:0] wd = '0;
  logic [AW-1:0]    ra1 = '0;
  logic [AW-1:0]    ra2 = '0;
  logic [WIDTH-1:0] rd1, rd2;
  logic             issue_en = 1'b0;
  logic [AW-1:0]    issue_addr = '0;
  logic             busy1, busy2;

  regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready),
    .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy1(busy1), .busy2(busy2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] m_rf [DEPTH];
  logic [DEPTH-1:0] m_busy = '0;
  int               sweep_left = DEPTH;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] exp_rd(input logic [AW-1:0] a);
    if (sweep_left != 0 || a == 0) return '0;
`ifdef REGFILE_SB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return m_rf[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (sweep_left != 0 || a == 0) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
    if (we && wa == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic model_edge();
    if (sweep_left > 0) begin
      m_rf[DEPTH - sweep_left] = '0;
      sweep_left--;
    end else if (clr_req) begin
      sweep_left = DEPTH;
      m_busy = '0;
    end else begin
      if (we && wa != 0) begin
        m_rf[wa] = wd;
        m_busy[wa] = 1'b0;
      end
      if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    we = 1'b0; issue_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    #1;
    check({tag, ".ready"}, {31'b0, ready}, {31'b0, sweep_left == 0});
    check({tag, ".rd1"}, rd1, exp_rd(ra1));
    check({tag, ".rd2"}, rd2, exp_rd(ra2));
    check({tag, ".busy1"}, {31'b0, busy1}, {31'b0, exp_busy(ra1)});
    check({tag, ".busy2"}, {31'b0, busy2}, {31'b0, exp_busy(ra2)});
  endtask

  task automatic sweep_and_check(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      check({tag, ".not_ready"}, {31'b0, ready}, 32'd0);
      tick();
    end
    #1;
    check({tag, ".ready_up"}, {31'b0, ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_rf[i] = '0;
    #1;
    check("reset.ready", {31'b0, ready}, 32'd0);
    check("reset.rd1", rd1, 32'd0);
    check("reset.busy1", {31'b0, busy1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_left = DEPTH;
    sweep_and_check("sweep0");

    // Fill every register with ones, then reset and confirm the sweep erases them.
    for (int i = 0; i < DEPTH; i++) begin
      we = 1'b1; wa = AW'(i); wd = 32'hFFFF_FFFF;
      tick();
    end
    idle_inputs();
    rst_n = 1'b0;
    m_busy = '0; sweep_left = DEPTH;
    @(negedge clk);
    rst_n = 1'b1;
    sweep_and_check("sweep1");
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = AW'(i); ra2 = AW'(DEPTH - 1 - i);
      #1;
      check("sweep1.zero1", rd1, 32'd0);
      check("sweep1.zero2", rd2, 32'd0);
    end
    @(negedge clk);

    we = 1'b1; wa = 5; wd = 32'hDEAD_BEEF;
    tick();
    idle_inputs(); ra1 = 5; ra2 = 0;
    #1;
    check("wr5.rd1", rd1, 32'hDEAD_BEEF);
    check("wr5.rd2", rd2, 32'd0);
    @(negedge clk);
    we = 1'b1; wa = 0; wd = 32'h1234;
    tick();
    idle_inputs(); ra1 = 0;
    #1;
    check("zero.rd1", rd1, 32'd0);
    @(negedge clk);

    issue_en = 1'b1; issue_addr = 7;
    tick();
    idle_inputs(); ra1 = 7;
    #1;
    check("sb.issue", {31'b0, busy1}, 32'd1);
    @(negedge clk);
    we = 1'b1; wa = 7; wd = 32'h0000_0707;
    tick();
    idle_inputs();
    #1;
    check("sb.write_clears", {31'b0, busy1}, 32'd0);
    @(negedge clk);
    we = 1'b1; wa = 7; wd = 32'h0000_0777; issue_en = 1'b1; issue_addr = 7;
    tick();
    idle_inputs();
    #1;
    check("sb.both_busy", {31'b0, busy1}, 32'd1);
    check("sb.both_rd", rd1, 32'h0000_0777);
    @(negedge clk);

    issue_en = 1'b1; issue_addr = 3;
    tick();
    idle_inputs();
    we = 1'b1; wa = 3; wd = 32'hA5A5_A5A5; ra1 = 3;
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    check("byp.rd1", rd1, 32'hA5A5_A5A5);
    check("byp.busy1", {31'b0, busy1}, 32'd0);
`else
    check("nobyp.rd1", rd1, 32'd0);
    check("nobyp.busy1", {31'b0, busy1}, 32'd1);
`endif
    tick();
    idle_inputs();
    #1;
    check("byp.after_rd1", rd1, 32'hA5A5_A5A5);
    check("byp.after_busy1", {31'b0, busy1}, 32'd0);
    @(negedge clk);

    issue_en = 1'b1; issue_addr = 4;
    tick();
    we = 1'b1; wa = 9; wd = 32'h55; issue_en = 1'b0; clr_req = 1'b1;
    tick();
    idle_inputs();
    #1;
    check("clr.ready_drop", {31'b0, ready}, 32'd0);
    sweep_and_check("clr");
    ra1 = 9; ra2 = 4;
    #1;
    check("clr.rd9", rd1, 32'd0);
    check("clr.busy4", {31'b0, busy2}, 32'd0);
    @(negedge clk);

    // Async reset in IDLE with a busy register, then mid-sweep at cnt=10.
    issue_en = 1'b1; issue_addr = 12;
    tick();
    idle_inputs();
    #2 rst_n = 1'b0;
    m_busy = '0; sweep_left = DEPTH;
    #1;
    check("areset.ready", {31'b0, ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    #2 rst_n = 1'b0;
    sweep_left = DEPTH;
    #1;
    check("midsweep.ready", {31'b0, ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_and_check("midsweep");
    ra1 = 12;
    #1;
    check("areset.busy12", {31'b0, busy1}, 32'd0);
    @(negedge clk);

    for (int n = 0; n < 400; n++) begin
      we         = 1'($urandom_range(0, 1));
      wa         = AW'($urandom);
      wd         = $urandom;
      issue_en   = 1'($urandom_range(0, 2) == 0);
      issue_addr = AW'($urandom_range(0, 7));
      ra1        = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      ra2        = AW'($urandom_range(0, 7));
      clr_req    = ($urandom_range(0, 79) == 0);
      check_outputs("rand");
      tick();
    end
    idle_inputs();
    check_outputs("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
